// File: rtl/encoder16x4_rr.sv
// Registered round-robin 16-to-4 priority encoder with valid/ready output.
// Optional ENCODER_ONEHOT_CHECK_EN adds MultiErr (more than one request at capture).
module encoder16x4_rr #(
    parameter int WIDTH_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         En,
    input  logic [(1<<WIDTH_OUT)-1:0]    Y,
    input  logic                         Rdy,
    output logic [WIDTH_OUT-1:0]         X,
    output logic                         Valid,
    output logic                         Busy
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    output logic                         MultiErr
`endif
);

    localparam int N_IN = 1 << WIDTH_OUT;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t               state;
    logic [WIDTH_OUT-1:0] ptr;
    logic [WIDTH_OUT-1:0] sel;
    logic [WIDTH_OUT-1:0] idx;
    logic                 found;

    // Search upward from ptr; the index naturally wraps at WIDTH_OUT bits.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            idx = ptr + WIDTH_OUT'(i);
            if (!found && Y[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef ENCODER_ONEHOT_CHECK_EN
    localparam logic [N_IN-1:0] ONE = N_IN'(1);
    logic multi;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(Y & (Y - ONE));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            X     <= '0;
            Valid <= 1'b0;
`ifdef ENCODER_ONEHOT_CHECK_EN
            MultiErr <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (En && found) begin
                        X     <= sel;
                        Valid <= 1'b1;
                        state <= HOLD;
`ifdef ENCODER_ONEHOT_CHECK_EN
                        MultiErr <= multi;
`endif
                    end
                end
                HOLD: begin
                    if (Rdy) begin
                        ptr   <= X + WIDTH_OUT'(1);
                        Valid <= 1'b0;
                        state <= IDLE;
`ifdef ENCODER_ONEHOT_CHECK_EN
                        MultiErr <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = Valid;

endmodule

// File: doc/encoder16x4_rr.md
Name: encoder16x4_rr

Overview:
- Registered 16-to-4 round-robin priority encoder. It is the inverse companion of the team's 4x16 decoder.
- Takes a 16-bit request vector and produces the 4-bit index of one granted request.
- Index is presented with a Valid/Rdy handshake, so a downstream 4x16 decoder or consumer can take codes at its own pace.
- Rotating priority pointer guarantees no starvation among simultaneous requests.

Parameters:
WIDTH_OUT, 4, width of encoded index X; number of request lines N_IN = 2**WIDTH_OUT (16 by default); legal range 2..4.

Ports:
clk    input   1          rising-edge clock
rst_n  input   1          asynchronous active-low reset
En     input   1          capture enable; sampled only in IDLE
Y      input   N_IN       request vector, level-sensitive, bit k = request k
Rdy    input   1          downstream accepts X this cycle when Valid=1
X      output  WIDTH_OUT  registered encoded index of granted request
Valid  output  1          X holds a granted index awaiting acceptance
Busy   output  1          1 in HOLD state (equals Valid)

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-transaction):
  - X=0, Valid=0, Busy=0.
  - Internal pointer ptr=0, state=IDLE.
  - Any pending index is discarded.
- State IDLE:
  - If En=1 and Y!=0 at a rising edge: select the first set bit of Y, searching upward from ptr with wrap (ptr, ptr+1 ... N_IN-1, 0 ... ptr-1).
  - Register that index into X, set Valid=1, go to HOLD.
  - If En=0 or Y==0: stay in IDLE; X holds its last value; Valid=0.
- State HOLD:
  - X and Valid are stable; Y and En are ignored. Requests that drop or change do not alter X.
  - On a rising edge with Rdy=1: ptr <= X+1 (mod N_IN, natural wrap of WIDTH_OUT bits), Valid=0, go to IDLE.
  - Rdy=0: remain in HOLD indefinitely.
- Latency: request sampled at edge n -> Valid=1 after edge n.
- Throughput: one grant per 2 cycles minimum; the IDLE bubble after each acceptance is mandatory.
- Wrap: X=15 accepted -> ptr=0.
- Rdy while Valid=0: ignored, no effect.
- Single request bit k: X=k regardless of ptr.
- All 16 bits set continuously with Rdy=1: grants cycle 0,1,2,...,15,0 in order.

Optional Feature:
- Macro ENCODER_ONEHOT_CHECK_EN.
- When defined:
  - Extra output MultiErr (1 bit, reset 0).
  - Registered alongside X at capture: MultiErr=1 if more than one bit of Y was set at the capture edge, else 0.
  - Held stable in HOLD; cleared to 0 on acceptance.
  - Lets the decoder/encoder pair flag non-one-hot traffic.
- When undefined: no MultiErr port, no popcount logic. All other behaviour is identical.

Test Plan:
1. Reset, then Y=16'h0000, En=1 for 5 cycles -> Valid=0, X=0 throughout.
2. Sweep single-bit Y=1<<k for k=0..15, En=1, Rdy=1 -> X=k, Valid pulses 1 cycle per grant, 2-cycle period.
3. Y=16'hFFFF held, Rdy=1, 34 cycles -> X sequence 0,1,...,15,0; with ENCODER_ONEHOT_CHECK_EN, MultiErr=1 on every grant.
4. Y=16'h8004, Rdy=0 for 6 cycles after grant X=2, then Y changed to 16'h0001 -> X stays 2, Valid stays 1. Then Rdy=1 -> accept, ptr=3; next grant X=0 (bit 0 is the only request).
5. Grant X=15 pending, assert rst_n=0 asynchronously mid-cycle -> Valid=0 and X=0 immediately. After release, Y=16'h8001 -> X=0 (ptr reset to 0).
6. Y=16'h0003, En toggled 0 in IDLE for 3 cycles -> no grant; En=1 -> X=0, then X=1 after acceptance.
